// File: rtl/vj_scale_pkg.sv
// Shared types and helpers for the pyramid downscaler: ratio format, FSM states,
// and the ratio clamp that forbids upscaling.
package vj_scale_pkg;

    localparam int INT_W   = 8;
    localparam int FRAC_W  = 8;
    localparam int RATIO_W = INT_W + FRAC_W;

    typedef logic [RATIO_W-1:0] ratio_t;

    localparam ratio_t RATIO_ONE = ratio_t'(1 << FRAC_W);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Ratios below 1.0 would upscale; they are pinned to exactly 1.0.
    function automatic logic [31:0] clamp_ratio(input logic [31:0] ratio,
                                                input int unsigned frac_w);
        logic [31:0] one;
        one = 32'd1 << frac_w;
        return (ratio < one) ? one : ratio;
    endfunction

endpackage

// File: rtl/scale_axis_stepper.sv
// One axis of the nearest-neighbour selector: input position, saturating
// fixed-point source accumulator, emitted count and the match/last/final flags.
module scale_axis_stepper #(
    parameter int N       = 8,
    parameter int LIMIT   = 8,
    parameter int FRAC_W  = 8,
    parameter int RATIO_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [RATIO_W-1:0] i_ratio,
    input  logic               i_restart,
    input  logic               i_step,
    input  logic               i_adv,
    output logic               o_match,
    output logic               o_last_pos,
    output logic               o_final
);
    localparam int PW = $clog2(N) + 1;
    localparam int AW = PW + FRAC_W;
    localparam int CW = $clog2(LIMIT + 1);
    localparam int SW = ((AW > RATIO_W) ? AW : RATIO_W) + 1;

    // Saturating add keeps an accumulator that ran past the edge past the edge.
    function automatic logic [AW-1:0] sat_add(input logic [AW-1:0]      a,
                                              input logic [RATIO_W-1:0] r);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(r);
        return (s > SW'({AW{1'b1}})) ? {AW{1'b1}} : s[AW-1:0];
    endfunction

    logic [PW-1:0] r_pos;
    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] w_pos;
    logic [AW-1:0] w_acc;
    logic [AW-1:0] w_acc_nxt;
    logic [CW-1:0] w_cnt;

    // A restart beat is itself position zero, so the current view is forced to zero.
    assign w_pos     = i_restart ? '0 : r_pos;
    assign w_acc     = i_restart ? '0 : r_acc;
    assign w_cnt     = i_restart ? '0 : r_cnt;
    assign w_acc_nxt = sat_add(w_acc, i_ratio);

    assign o_match    = (w_pos == w_acc[AW-1:FRAC_W]) && (w_cnt < CW'(LIMIT));
    assign o_last_pos = (w_pos == PW'(N - 1));
    assign o_final    = (w_cnt == CW'(LIMIT - 1)) || (w_acc_nxt[AW-1:FRAC_W] > PW'(N - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pos <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_step) begin
            if (o_last_pos) begin
                r_pos <= '0;
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_pos <= w_pos + 1'b1;
                r_acc <= i_adv ? w_acc_nxt : w_acc;
                r_cnt <= i_adv ? w_cnt + 1'b1 : w_cnt;
            end
        end else if (i_restart) begin
            r_pos <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/stream_downscaler.sv
// Streaming nearest-neighbour downscaler: consumes a raster stream and emits
// input[floor(i*r)][floor(j*r)] through a single registered output stage.
`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 640
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 480
`endif

module stream_downscaler #(
    parameter int IN_W      = `LAPTOP_WIDTH,
    parameter int IN_H      = `LAPTOP_HEIGHT,
    parameter int OUT_W_MAX = `LAPTOP_WIDTH,
    parameter int OUT_H_MAX = `LAPTOP_HEIGHT,
    parameter int PIX_W     = 32,
    parameter int FRAC_W    = 8,
    parameter int INT_W     = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [INT_W+FRAC_W-1:0] cfg_ratio,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PIX_W-1:0]        in_pixel,
    input  logic                    in_sof,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PIX_W-1:0]        out_pixel,
    output logic                    out_sof,
    output logic                    out_eol,
    output logic                    out_eof,
    output logic                    sof_err
);
    import vj_scale_pkg::*;

    localparam int RW = INT_W + FRAC_W;

    state_t          r_state;
    logic [RW-1:0]   r_ratio;
    logic            r_sof_err;
    logic            r_out_valid;
    logic [PIX_W-1:0] r_out_pixel;
    logic            r_out_sof;
    logic            r_out_eol;
    logic            r_out_eof;

    logic [RW-1:0]   w_ratio;
    logic            w_accept;
    logic            w_sof_beat;
    logic            w_frame_beat;
    logic            w_emit;
    logic            w_x_match;
    logic            w_x_last;
    logic            w_x_final;
    logic            w_y_match;
    logic            w_y_last;
    logic            w_y_final;

    assign in_ready     = !r_out_valid || out_ready;
    assign w_accept     = in_valid && in_ready;
    assign w_sof_beat   = w_accept && in_sof;
    // IDLE swallows non-SOF beats; only frame beats move the counters.
    assign w_frame_beat = w_accept && (in_sof || (r_state == ST_ACTIVE));
    assign w_ratio      = w_sof_beat ? RW'(clamp_ratio(32'(cfg_ratio), FRAC_W)) : r_ratio;
    assign w_emit       = w_frame_beat && w_x_match && w_y_match;

    scale_axis_stepper #(
        .N       (IN_W),
        .LIMIT   (OUT_W_MAX),
        .FRAC_W  (FRAC_W),
        .RATIO_W (RW)
    ) u_x_axis (
        .clock      (clock),
        .reset      (reset),
        .i_ratio    (w_ratio),
        .i_restart  (w_sof_beat),
        .i_step     (w_frame_beat),
        .i_adv      (w_emit),
        .o_match    (w_x_match),
        .o_last_pos (w_x_last),
        .o_final    (w_x_final)
    );

    scale_axis_stepper #(
        .N       (IN_H),
        .LIMIT   (OUT_H_MAX),
        .FRAC_W  (FRAC_W),
        .RATIO_W (RW)
    ) u_y_axis (
        .clock      (clock),
        .reset      (reset),
        .i_ratio    (w_ratio),
        .i_restart  (w_sof_beat),
        .i_step     (w_frame_beat && w_x_last),
        .i_adv      (w_y_match),
        .o_match    (w_y_match),
        .o_last_pos (w_y_last),
        .o_final    (w_y_final)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ratio   <= '0;
            r_sof_err <= 1'b0;
        end else begin
            r_sof_err <= w_sof_beat && (r_state == ST_ACTIVE);
            if (w_sof_beat) begin
                r_ratio <= w_ratio;
            end
            if (w_frame_beat) begin
                r_state <= (w_x_last && w_y_last) ? ST_IDLE : ST_ACTIVE;
            end
        end
    end

    // Output stage: reloads only when the previous word has left or none is held.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_out_eof   <= 1'b0;
        end else if (in_ready) begin
            r_out_valid <= w_emit;
            r_out_sof   <= w_emit && w_sof_beat;
            r_out_eol   <= w_emit && w_x_final;
            r_out_eof   <= w_emit && w_x_final && w_y_final;
            if (w_emit) begin
                r_out_pixel <= in_pixel;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_pixel = r_out_pixel;
    assign out_sof   = r_out_sof;
    assign out_eol   = r_out_eol;
    assign out_eof   = r_out_eof;
    assign sof_err   = r_sof_err;

endmodule

// File: tb/tb_stream_downscaler.sv
// Directed bench for stream_downscaler on an 8x6 frame, plus a 5x2-capped instance.
module tb_stream_downscaler;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic [15:0] cfg_ratio = 16'h0100;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [31:0] in_pixel = '0;
    logic        out_ready = 1'b1;
    logic        sel2 = 1'b0;

    logic        v1, v2, rdy1, rdy2, ov1, ov2;
    logic        sof1, eol1, eof1, err1, sof2, eol2, eof2, err2;
    logic [31:0] px1, px2;

    assign v1 = in_valid && !sel2;
    assign v2 = in_valid && sel2;

    stream_downscaler #(
        .IN_W(8), .IN_H(6), .OUT_W_MAX(8), .OUT_H_MAX(6), .PIX_W(32), .FRAC_W(8), .INT_W(8)
    ) dut1 (
        .clock(clock), .reset(reset), .cfg_ratio(cfg_ratio),
        .in_valid(v1), .in_ready(rdy1), .in_pixel(in_pixel), .in_sof(in_sof),
        .out_valid(ov1), .out_ready(out_ready), .out_pixel(px1),
        .out_sof(sof1), .out_eol(eol1), .out_eof(eof1), .sof_err(err1)
    );

    stream_downscaler #(
        .IN_W(8), .IN_H(6), .OUT_W_MAX(5), .OUT_H_MAX(2), .PIX_W(32), .FRAC_W(8), .INT_W(8)
    ) dut2 (
        .clock(clock), .reset(reset), .cfg_ratio(cfg_ratio),
        .in_valid(v2), .in_ready(rdy2), .in_pixel(in_pixel), .in_sof(in_sof),
        .out_valid(ov2), .out_ready(out_ready), .out_pixel(px2),
        .out_sof(sof2), .out_eol(eol2), .out_eof(eof2), .sof_err(err2)
    );

    int tot = 0;
    int bad = 0;

    logic [31:0] q1_pix[$];
    logic [2:0]  q1_fl[$];
    logic [31:0] q2_pix[$];
    logic [2:0]  q2_fl[$];
    int          err_pulses = 0;
    int          stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [34:0] prev_out = '0;

    always @(negedge clock) begin
        if (ov1 === 1'b1 && out_ready === 1'b1) begin
            q1_pix.push_back(px1);
            q1_fl.push_back({sof1, eol1, eof1});
        end
        if (ov2 === 1'b1 && out_ready === 1'b1) begin
            q2_pix.push_back(px2);
            q2_fl.push_back({sof2, eol2, eof2});
        end
        if (err1 === 1'b1) err_pulses++;
        if (prev_stall && !(ov1 === 1'b1 && {px1, sof1, eol1, eof1} === prev_out)) stall_viol++;
        prev_stall = (ov1 === 1'b1) && (out_ready === 1'b0);
        prev_out   = {px1, sof1, eol1, eof1};
    end

    logic       stall_en = 1'b0;
    logic [7:0] lfsr = 8'hA5;
    always @(posedge clock) begin
        #1;
        if (stall_en) begin
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            out_ready = lfsr[0];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [31:0] pix, input logic sof);
        int n;
        in_valid = 1'b1;
        in_pixel = pix;
        in_sof   = sof;
        n = 0;
        @(negedge clock);
        while (!(sel2 ? rdy2 : rdy1) && n < 200) begin
            n++;
            @(negedge clock);
        end
        if (n >= 200) begin
            tot++; bad++;
            $display("FAIL drive_timeout pixel=%0d got in_ready=0 want in_ready=1", pix);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        tot++;
        if ({ov1, px1, sof1, eol1, eof1, err1} !== 37'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {ov1, px1, sof1, eol1, eof1, err1});
        end
        tot++;
        if (rdy1 !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", rdy1);
        end
        for (int k = 0; k < 3; k++) drive(32'(100 + k), 1'b0);
        drain();
        tot++;
        if (q1_pix.size() != 0) begin
            bad++;
            $display("FAIL idle_discard got=%0d outputs want=0", q1_pix.size());
        end
    endtask

    task automatic test_passthrough();
        q1_pix.delete(); q1_fl.delete();
        cfg_ratio = 16'h0100;
        drive(32'd0, 1'b1);
        tot++;
        if (!(ov1 === 1'b1 && px1 === 32'd0 && sof1 === 1'b1)) begin
            bad++;
            $display("FAIL latency1 got valid=%b pix=%0d sof=%b want valid=1 pix=0 sof=1", ov1, px1, sof1);
        end
        for (int k = 1; k < 48; k++) drive(32'(k), 1'b0);
        drain();
        tot++;
        if (q1_pix.size() != 48) begin
            bad++;
            $display("FAIL pass_count got=%0d want=48", q1_pix.size());
        end
        for (int i = 0; i < 48; i++) begin
            logic [2:0] ef;
            ef = {i == 0, i % 8 == 7, i == 47};
            tot++;
            if (i >= q1_pix.size()) begin
                bad++; $display("FAIL pass_missing idx=%0d", i);
            end else if ({q1_pix[i], q1_fl[i]} !== {32'(i), ef}) begin
                bad++;
                $display("FAIL pass idx=%0d got=%0d/%b want=%0d/%b", i, q1_pix[i], q1_fl[i], i, ef);
            end
        end
    endtask

    task automatic test_ratio2();
        int exp2 [12] = '{0, 2, 4, 6, 16, 18, 20, 22, 32, 34, 36, 38};
        q1_pix.delete(); q1_fl.delete();
        cfg_ratio = 16'h0200;
        for (int k = 0; k < 48; k++) drive(32'(k), k == 0);
        drain();
        tot++;
        if (q1_pix.size() != 12) begin
            bad++; $display("FAIL r2_count got=%0d want=12", q1_pix.size());
        end
        for (int i = 0; i < 12; i++) begin
            logic [2:0] ef;
            ef = {i == 0, i % 4 == 3, i == 11};
            tot++;
            if (i >= q1_pix.size()) begin
                bad++; $display("FAIL r2_missing idx=%0d", i);
            end else if ({q1_pix[i], q1_fl[i]} !== {32'(exp2[i]), ef}) begin
                bad++;
                $display("FAIL r2 idx=%0d got=%0d/%b want=%0d/%b", i, q1_pix[i], q1_fl[i], exp2[i], ef);
            end
        end
    endtask

    task automatic test_ratio15();
        int cols [6] = '{0, 1, 3, 4, 6, 7};
        int rows [4] = '{0, 1, 3, 4};
        q1_pix.delete(); q1_fl.delete();
        cfg_ratio = 16'h0180;
        for (int k = 0; k < 48; k++) drive(32'(k), k == 0);
        drain();
        tot++;
        if (q1_pix.size() != 24) begin
            bad++; $display("FAIL r15_count got=%0d want=24", q1_pix.size());
        end
        for (int i = 0; i < 24; i++) begin
            logic [2:0] ef;
            int ev;
            ev = 8 * rows[i / 6] + cols[i % 6];
            ef = {i == 0, i % 6 == 5, i == 23};
            tot++;
            if (i >= q1_pix.size()) begin
                bad++; $display("FAIL r15_missing idx=%0d", i);
            end else if ({q1_pix[i], q1_fl[i]} !== {32'(ev), ef}) begin
                bad++;
                $display("FAIL r15 idx=%0d got=%0d/%b want=%0d/%b", i, q1_pix[i], q1_fl[i], ev, ef);
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        int exp2 [12] = '{0, 2, 4, 6, 16, 18, 20, 22, 32, 34, 36, 38};
        q1_pix.delete(); q1_fl.delete();
        stall_viol = 0;
        cfg_ratio = 16'h0200;
        stall_en = 1'b1;
        for (int k = 0; k < 48; k++) drive(32'(k), k == 0);
        stall_en = 1'b0;
        out_ready = 1'b1;
        drain();
        tot++;
        if (stall_viol != 0) begin
            bad++; $display("FAIL stall_hold got=%0d changes want=0", stall_viol);
        end
        tot++;
        if (q1_pix.size() != 12) begin
            bad++; $display("FAIL stall_count got=%0d want=12", q1_pix.size());
        end
        for (int i = 0; i < 12; i++) begin
            logic [2:0] ef;
            ef = {i == 0, i % 4 == 3, i == 11};
            tot++;
            if (i >= q1_pix.size()) begin
                bad++; $display("FAIL stall_missing idx=%0d", i);
            end else if ({q1_pix[i], q1_fl[i]} !== {32'(exp2[i]), ef}) begin
                bad++;
                $display("FAIL stall idx=%0d got=%0d/%b want=%0d/%b", i, q1_pix[i], q1_fl[i], exp2[i], ef);
            end
        end
    endtask

    task automatic test_clamp_and_limits();
        q1_pix.delete(); q1_fl.delete();
        cfg_ratio = 16'h0080;
        for (int k = 0; k < 48; k++) drive(32'(k), k == 0);
        drain();
        tot++;
        if (q1_pix.size() != 48) begin
            bad++; $display("FAIL clamp_count got=%0d want=48", q1_pix.size());
        end
        for (int i = 0; i < 48; i++) begin
            logic [2:0] ef;
            ef = {i == 0, i % 8 == 7, i == 47};
            tot++;
            if (i >= q1_pix.size()) begin
                bad++; $display("FAIL clamp_missing idx=%0d", i);
            end else if ({q1_pix[i], q1_fl[i]} !== {32'(i), ef}) begin
                bad++;
                $display("FAIL clamp idx=%0d got=%0d/%b want=%0d/%b", i, q1_pix[i], q1_fl[i], i, ef);
            end
        end
        sel2 = 1'b1;
        q2_pix.delete(); q2_fl.delete();
        cfg_ratio = 16'h0100;
        for (int k = 0; k < 48; k++) drive(32'(k), k == 0);
        drain();
        sel2 = 1'b0;
        tot++;
        if (q2_pix.size() != 10) begin
            bad++; $display("FAIL limit_count got=%0d want=10", q2_pix.size());
        end
        for (int i = 0; i < 10; i++) begin
            logic [2:0] ef;
            int ev;
            ev = (i < 5) ? i : 8 + (i - 5);
            ef = {i == 0, (i == 4) || (i == 9), i == 9};
            tot++;
            if (i >= q2_pix.size()) begin
                bad++; $display("FAIL limit_missing idx=%0d", i);
            end else if ({q2_pix[i], q2_fl[i]} !== {32'(ev), ef}) begin
                bad++;
                $display("FAIL limit idx=%0d got=%0d/%b want=%0d/%b", i, q2_pix[i], q2_fl[i], ev, ef);
            end
        end
    endtask

    task automatic test_sof_restart();
        q1_pix.delete(); q1_fl.delete();
        err_pulses = 0;
        cfg_ratio = 16'h0100;
        for (int k = 0; k < 20; k++) drive(32'(k), k == 0);
        for (int k = 0; k < 48; k++) drive(32'(k), k == 0);
        drain();
        tot++;
        if (err_pulses != 1) begin
            bad++; $display("FAIL sof_err_pulses got=%0d want=1", err_pulses);
        end
        tot++;
        if (q1_pix.size() != 68) begin
            bad++; $display("FAIL restart_count got=%0d want=68", q1_pix.size());
        end
        for (int i = 0; i < 68; i++) begin
            logic [2:0] ef;
            int ev;
            ev = (i < 20) ? i : i - 20;
            ef = {(i == 0) || (i == 20), ev % 8 == 7, i == 67};
            tot++;
            if (i >= q1_pix.size()) begin
                bad++; $display("FAIL restart_missing idx=%0d", i);
            end else if ({q1_pix[i], q1_fl[i]} !== {32'(ev), ef}) begin
                bad++;
                $display("FAIL restart idx=%0d got=%0d/%b want=%0d/%b", i, q1_pix[i], q1_fl[i], ev, ef);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int exp2 [12] = '{0, 2, 4, 6, 16, 18, 20, 22, 32, 34, 36, 38};
        q1_pix.delete(); q1_fl.delete();
        err_pulses = 0;
        cfg_ratio = 16'h0100;
        for (int k = 0; k < 10; k++) drive(32'(k), k == 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        tot++;
        if (ov1 !== 1'b0) begin
            bad++; $display("FAIL reset_drop got valid=%b want=0", ov1);
        end
        for (int k = 10; k < 20; k++) drive(32'(k), 1'b0);
        drain();
        tot++;
        if (q1_pix.size() != 10) begin
            bad++; $display("FAIL reset_ignore got=%0d outputs want=10", q1_pix.size());
        end
        cfg_ratio = 16'h0200;
        for (int k = 0; k < 48; k++) drive(32'(k), k == 0);
        drain();
        tot++;
        if (q1_pix.size() != 22) begin
            bad++; $display("FAIL reset_recover_count got=%0d want=22", q1_pix.size());
        end
        for (int i = 0; i < 12; i++) begin
            tot++;
            if (10 + i >= q1_pix.size()) begin
                bad++; $display("FAIL recover_missing idx=%0d", i);
            end else if (q1_pix[10 + i] !== 32'(exp2[i])) begin
                bad++;
                $display("FAIL recover idx=%0d got=%0d want=%0d", i, q1_pix[10 + i], exp2[i]);
            end
        end
        tot++;
        if (err_pulses != 0) begin
            bad++; $display("FAIL reset_no_err got=%0d want=0", err_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_ratio2();
        test_ratio15();
        test_back_to_back_stall();
        test_clamp_and_limits();
        test_sof_restart();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule

// File: doc/stream_downscaler.md
Name: stream_downscaler

Overview:
Streaming nearest-neighbour downscaler for the Viola-Jones image pyramid. It replaces the fixed, fully-combinational ratio-table downscaler. It accepts one raster-scan pixel per cycle over a valid/ready handshake and emits the pixels selected by a runtime-programmable fixed-point scale ratio. The output is a raster stream with row and frame markers, which feeds integral-image generation for each pyramid level.

Parameters:
IN_W, `LAPTOP_WIDTH, input frame width in pixels
IN_H, `LAPTOP_HEIGHT, input frame height in pixels
OUT_W_MAX, `LAPTOP_WIDTH, maximum emitted pixels per output row
OUT_H_MAX, `LAPTOP_HEIGHT, maximum emitted output rows per frame
PIX_W, 32, pixel width
FRAC_W, 8, fractional bits of the ratio
INT_W, 8, integer bits of the ratio

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_ratio  in  INT_W+FRAC_W  scale ratio (source pixels per output pixel), unsigned Q(INT_W.FRAC_W); sampled on the accepted SOF beat
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept an input pixel
in_pixel  in  PIX_W  input pixel
in_sof  in  1  first pixel of the input frame
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts
out_pixel  out  PIX_W  selected pixel
out_sof  out  1  first emitted pixel of the frame
out_eol  out  1  last emitted pixel of the output row
out_eof  out  1  last emitted pixel of the frame
sof_err  out  1  one-cycle pulse: in_sof seen mid-frame

Behaviour:
- Reset: all outputs are 0, and the block enters the IDLE state.
- States:
  - IDLE: waits for an accepted beat with in_sof=1.
  - ACTIVE: processing the frame.
  - The block returns to IDLE after accepting input pixel (IN_W-1, IN_H-1).
- While in IDLE, beats with in_sof=0 are accepted and discarded.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready, so there is a single registered output stage.
  - A selected pixel appears on out_pixel the cycle after acceptance, giving a latency of 1.
  - out_* fields hold steady while out_valid && !out_ready.
  - Every input beat is consumed, whether it is emitted or dropped.
- Ratio latch:
  - ratio_q = cfg_ratio on the accepted SOF beat.
  - A value below 1.0 (cfg_ratio < 1<<FRAC_W) is clamped to exactly 1.0; upscaling is not supported.
- Counters:
  - x runs 0..IN_W-1 and y runs 0..IN_H-1, input position of the accepted beat.
  - x_acc and y_acc are fixed-point accumulators, each with int part wide enough for IN_W/IN_H plus one guard bit.
  - ox and oy count emitted columns and rows.
- Row select:
  - row_sel = (y == int(y_acc)) && (oy < OUT_H_MAX).
- Emit condition:
  - Emit when row_sel && (x == int(x_acc)) && (ox < OUT_W_MAX).
  - On emit: x_acc += ratio_q and ox += 1.
- End of input row (x == IN_W-1):
  - x, x_acc and ox clear.
  - If row_sel: y_acc += ratio_q and oy += 1.
  - y increments.
- Since ratio >= 1.0, each input pixel is emitted at most once.
- Markers:
  - out_eol = emitted && (ox == OUT_W_MAX-1 || int(x_acc+ratio_q) > IN_W-1).
  - out_eof = out_eol && (oy == OUT_H_MAX-1 || int(y_acc+ratio_q) > IN_H-1).
  - out_sof = first emit of the frame.
- Accumulator arithmetic saturates at all-ones instead of wrapping, so a "past edge" condition stays past edge.
- in_sof while ACTIVE:
  - sof_err pulses.
  - Counters and accumulators restart with that beat as pixel (0,0) and ratio_q is re-latched.
  - An output already registered still drains normally.
- Reset mid-frame: the output register is dropped immediately; out_valid=0 the next cycle.
- Selection equals output[i][j] = input[floor(i*r)][floor(j*r)], truncated to OUT_H_MAX x OUT_W_MAX.

Decomposition:
- Package vj_scale_pkg holds:
  - ratio_t (INT_W+FRAC_W fixed point)
  - FRAC_W/INT_W constants
  - RATIO_ONE
  - clamp function
- Sub-module scale_axis_stepper (position counter, saturating accumulator, match/last flags) is instantiated once for x and once for y.

Test Plan (IN_W=8, IN_H=6, OUT_W_MAX=8, OUT_H_MAX=6, FRAC_W=8):
- ratio 0x100, 48 pixels with value = 8y+x, out_ready=1 -> 48 outputs in order; eol on x=7; eof on pixel 47; latency 1 cycle.
- ratio 0x200 -> 12 outputs in 4x3: values 0,2,4,6,16,18,...,38; eol on 6/22/38; eof on 38.
- ratio 0x180 -> columns 0,1,3,4,6,7 and rows 0,1,3,4 -> 24 outputs; first row 0,1,3,4,6,7.
- ratio 0x200, out_ready toggled pseudo-randomly -> identical 12-value sequence; no pixel lost or duplicated; out_* stable while stalled.
- ratio 0x080 -> clamped to 1.0, giving full passthrough. Then OUT_W_MAX=5, OUT_H_MAX=2 at ratio 1.0 -> 10 outputs, eol after x=4.
- in_sof reasserted at pixel 20, and reset pulsed at pixel 10 of another frame -> sof_err pulses once and the frame restarts at that beat; reset gives out_valid=0 next cycle and the block ignores pixels until the next SOF.
